mem_access_ctrl: RTL and testbench

Load/store access controller between the ARMv4 core datapath and the single-port data memory. It accepts byte or word load/store requests from the core over a valid/ready handshake, drives the memory's ADDRESS/WRITE/IN_DATA side, and captures OUT_DATA. It returns one response per request. Byte stores run as read-modify-write, because the memory has no byte enables.

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/byte_lane_unit.sv | 35 +++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the load/store access controller
package mem_access_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    ERR
  } state_t;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - little-endian byte extraction and byte merge for one memory word
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  lane_t                 lane,
  input  logic [DATA_SIZE-1:0]  word,
  input  logic [7:0]            store_byte,
  output logic [DATA_SIZE-1:0]  load_byte,
  output logic [DATA_SIZE-1:0]  merged
);

  always_comb begin
    load_byte = '0;
    merged    = word;
    case (lane)
      2'd0: begin
        load_byte[7:0] = word[7:0];
        merged[7:0]    = store_byte;
      end
      2'd1: begin
        load_byte[7:0] = word[15:8];
        merged[15:8]   = store_byte;
      end
      2'd2: begin
        load_byte[7:0] = word[23:16];
        merged[23:16]  = store_byte;
      end
      default: begin
        load_byte[7:0] = word[31:24];
        merged[31:24]  = store_byte;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/word load/store controller for a single-port word memory
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDRESS_SIZE = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WRITE,
  input  logic                    REQ_BYTE,
  input  logic [31:0]             REQ_ADDR,
  input  logic [DATA_SIZE-1:0]    REQ_WDATA,
  output logic                    RSP_VALID,
  output logic [DATA_SIZE-1:0]    RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
  output logic                    MEM_WRITE,
  output logic [DATA_SIZE-1:0]    MEM_WDATA,
  input  logic [DATA_SIZE-1:0]    MEM_RDATA
);

  state_t                  state, state_n;
  logic                    wr_q, wr_n;
  logic                    byte_q, byte_n;
  lane_t                   lane_q, lane_n;
  logic [7:0]              sbyte_q, sbyte_n;
  logic [ADDRESS_SIZE-1:0] mem_address_n;
  logic                    mem_write_n;
  logic [DATA_SIZE-1:0]    mem_wdata_n;
  logic                    rsp_valid_n;
  logic [DATA_SIZE-1:0]    rsp_rdata_n;
  logic                    rsp_err_n;
  logic [DATA_SIZE-1:0]    load_byte;
  logic [DATA_SIZE-1:0]    merged;
  logic                    misaligned;
  logic                    unused_addr;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign unused_addr = ^REQ_ADDR[31:ADDRESS_SIZE+2];
  assign misaligned  = !REQ_BYTE && (REQ_ADDR[1:0] != 2'b00);
  assign REQ_READY   = (state == IDLE) && !RST;

  byte_lane_unit u_lane (
    .lane       (lane_q),
    .word       (MEM_RDATA),
    .store_byte (sbyte_q),
    .load_byte  (load_byte),
    .merged     (merged)
  );

  always_comb begin
    state_n       = state;
    wr_n          = wr_q;
    byte_n        = byte_q;
    lane_n        = lane_q;
    sbyte_n       = sbyte_q;
    mem_address_n = MEM_ADDRESS;
    mem_write_n   = 1'b0;
    mem_wdata_n   = MEM_WDATA;
    rsp_valid_n   = 1'b0;
    rsp_rdata_n   = RSP_RDATA;
    rsp_err_n     = RSP_ERR;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          wr_n    = REQ_WRITE;
          byte_n  = REQ_BYTE;
          lane_n  = REQ_ADDR[1:0];
          sbyte_n = REQ_WDATA[7:0];
          if (misaligned) begin
            state_n = ERR;
          end else begin
            mem_address_n = REQ_ADDR[ADDRESS_SIZE+1:2];
            if (REQ_WRITE && !REQ_BYTE) begin
              mem_write_n = 1'b1;
              mem_wdata_n = REQ_WDATA;
              state_n     = WR;
            end else begin
              state_n = RD1;
            end
          end
        end
      end
      RD1: state_n = RD2;
      RD2: begin
        if (wr_q) begin
          // Byte store: write back the read word with one lane replaced.
          mem_wdata_n = merged;
          mem_write_n = 1'b1;
          state_n     = WR;
        end else begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = byte_q ? load_byte : MEM_RDATA;
          rsp_err_n   = 1'b0;
          state_n     = IDLE;
        end
      end
      WR: begin
        rsp_valid_n = 1'b1;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b0;
        state_n     = IDLE;
      end
      ERR: begin
        rsp_valid_n = 1'b1;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= '0;
      sbyte_q     <= '0;
      MEM_ADDRESS <= '0;
      MEM_WRITE   <= 1'b0;
      MEM_WDATA   <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
    end else begin
      state       <= state_n;
      wr_q        <= wr_n;
      byte_q      <= byte_n;
      lane_q      <= lane_n;
      sbyte_q     <= sbyte_n;
      MEM_ADDRESS <= mem_address_n;
      MEM_WRITE   <= mem_write_n;
      MEM_WDATA   <= mem_wdata_n;
      RSP_VALID   <= rsp_valid_n;
      RSP_RDATA   <= rsp_rdata_n;
      RSP_ERR     <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a 1-cycle registered memory
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic        REQ_BYTE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [7:0]  MEM_ADDRESS;
  logic        MEM_WRITE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          n_wr;
    logic        store;
    logic [7:0]  idx;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  exp_t        new_e;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        load_init;
  int          edge_cnt = 0;
  int          wr_pulses = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_access_ctrl #(.ADDRESS_SIZE(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_WRITE   (REQ_WRITE),
    .REQ_BYTE    (REQ_BYTE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_WRITE   (MEM_WRITE),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_RDATA   (MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 ^ (i * 32'h00010307);
  endfunction

  always @(posedge CLK) begin
    if (load_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WDATA;
      MEM_RDATA <= mem[MEM_ADDRESS];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic w, input logic b, input logic [31:0] a,
                                   input logic [31:0] d);
    exp_t        r;
    logic [1:0]  lane;
    logic [31:0] cur;
    logic [31:0] sh;
    lane    = a[1:0];
    r.idx   = a[9:2];
    cur     = ref_mem[a[9:2]];
    r.rdata = '0;
    r.err   = 1'b0;
    r.due   = 0;
    r.n_wr  = 0;
    r.store = 1'b0;
    r.word  = cur;
    if (!b && lane != 2'b00) begin
      r.err = 1'b1;
      r.due = 1;
    end else if (w && !b) begin
      r.store = 1'b1;
      r.word  = d;
      r.n_wr  = 1;
      r.due   = 1;
    end else if (w) begin
      r.store = 1'b1;
      r.word  = cur;
      r.word[8*lane +: 8] = d[7:0];
      r.n_wr  = 1;
      r.due   = 3;
    end else begin
      sh      = cur >> (8 * lane);
      r.rdata = b ? {24'h0, sh[7:0]} : cur;
      r.due   = 2;
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (load_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    end
    if (RST) begin
      q.delete();
      wr_pulses = 0;
    end else begin
      if (MEM_WRITE) begin
        wr_pulses++;
        if (q.size() == 0) begin
          check("stray_write", {63'h0, MEM_WRITE}, 64'h0);
        end else begin
          check("mem_address", {56'h0, MEM_ADDRESS}, {56'h0, q[0].idx});
          check("mem_wdata", {32'h0, MEM_WDATA}, {32'h0, q[0].word});
        end
      end
      if (RSP_VALID) begin
        if (q.size() == 0) begin
          check("stray_rsp", {63'h0, RSP_VALID}, 64'h0);
        end else begin
          mon_e = q.pop_front();
          check("rsp_cycle", 64'(edge_cnt), 64'(mon_e.due));
          check("rsp_rdata", {32'h0, RSP_RDATA}, {32'h0, mon_e.rdata});
          check("rsp_err", {63'h0, RSP_ERR}, {63'h0, mon_e.err});
          check("write_pulses", 64'(wr_pulses), 64'(mon_e.n_wr));
          if (mon_e.store) begin
            check("mem_word", {32'h0, mem[mon_e.idx]}, {32'h0, mon_e.word});
            ref_mem[mon_e.idx] = mon_e.word;
          end
        end
      end
      if (REQ_VALID && REQ_READY) begin
        new_e     = predict(REQ_WRITE, REQ_BYTE, REQ_ADDR, REQ_WDATA);
        new_e.due = edge_cnt + 1 + new_e.due;
        q.push_back(new_e);
        wr_pulses = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int hs_edge);
    int n;
    REQ_VALID = 1'b1;
    REQ_WRITE = w;
    REQ_BYTE  = b;
    REQ_ADDR  = a;
    REQ_WDATA = d;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!REQ_READY) check("handshake_timeout", {63'h0, REQ_READY}, 64'h1);
    @(posedge CLK);
    #1;
    hs_edge = edge_cnt;
    if (!hold) REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge CLK);
    while (q.size() != 0 && n < 30) begin
      n++;
      @(posedge CLK);
    end
    if (q.size() != 0) check("response_timeout", 64'(q.size()), 64'h0);
    #1;
  endtask

  initial begin
    int e1, e2, e3;
    RST       = 1'b1;
    load_init = 1'b1;
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0;
    REQ_BYTE  = 1'b0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", {63'h0, REQ_READY}, 64'h0);
    check("rst_mem_address", {56'h0, MEM_ADDRESS}, 64'h0);
    check("rst_mem_write", {63'h0, MEM_WRITE}, 64'h0);
    check("rst_mem_wdata", {32'h0, MEM_WDATA}, 64'h0);
    check("rst_rsp_valid", {63'h0, RSP_VALID}, 64'h0);
    check("rst_rsp_rdata", {32'h0, RSP_RDATA}, 64'h0);
    check("rst_rsp_err", {63'h0, RSP_ERR}, 64'h0);
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    load_init = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", {63'h0, REQ_READY}, 64'h1);
    @(posedge CLK);
    #1;

    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, e1);
    drain();
    check("word_store_mem", {32'h0, mem[4]}, 64'hDEADBEEF);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, e1);
    drain();
    issue(1'b1, 1'b1, 32'h12, 32'hFFFFFF55, 1'b0, e1);
    drain();
    check("byte_store_mem", {32'h0, mem[4]}, 64'hDE55BEEF);
    issue(1'b0, 1'b1, 32'h12, 32'h0, 1'b0, e1);
    drain();
    issue(1'b0, 1'b0, 32'h11, 32'h0, 1'b0, e1);
    drain();
    issue(1'b1, 1'b0, 32'h1A, 32'h12345678, 1'b0, e1);
    drain();
    check("misaligned_store_mem", {32'h0, mem[6]}, {32'h0, init_word(6)});
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 1'b1, 32'h40 + k, 32'h0, 1'b0, e1);
      drain();
    end
    issue(1'b1, 1'b1, 32'h23, 32'h000000C3, 1'b0, e1);
    drain();
    issue(1'b0, 1'b0, 32'h410, 32'h0, 1'b0, e1);
    drain();

    // Byte store aborted by reset while in RD2.
    issue(1'b1, 1'b1, 32'h13, 32'h00000099, 1'b0, e1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_abort", {63'h0, REQ_READY}, 64'h1);
    repeat (5) @(posedge CLK);
    #1;
    check("abort_mem_word", {32'h0, mem[4]}, 64'hDE55BEEF);

    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, e1);
    issue(1'b0, 1'b0, 32'h14, 32'h0, 1'b0, e2);
    check("back_to_back_edge", 64'(e2), 64'(e1 + 3));
    drain();

    for (int k = 0; k < 20; k++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, e3);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
